pulse_measure: RTL and testbench
================================

Name: pulse_measure

Overview:
- Receive-side counterpart to pulse_generator: observes a start strobe and the returned pulse, measures start-to-pulse delay and pulse width in clk cycles, and compares both against expected values.
- Sits in the same clock domain as pulse_generator; start and pulse_in are synchronous to clk.
- Presents one result per measurement through a valid/ready handshake for a checker or status register.

Parameters:
- COUNT_W, 16, width of the delay and width counters and result fields.
- EXPECTED_DELAY, 5, expected cycles from start sample to the pulse_in rising edge.
- EXPECTED_WIDTH, 10, expected cycles pulse_in is high.
- TIMEOUT_CYCLES, 1000, maximum cycles allowed in either measuring phase. Range is 1..2^COUNT_W-1.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  arms a measurement. Sampled only in IDLE.
- pulse_in  in  1  pulse under measurement (pulse_generator pulse_out).
- busy  out  1  high in every state except IDLE.
- meas_valid  out  1  result available.
- meas_ready  in  1  consumer accepts the result.
- delay_count  out  COUNT_W  measured delay in cycles.
- width_count  out  COUNT_W  measured width in cycles.
- delay_ok  out  1  delay_count == EXPECTED_DELAY and no timeout.
- width_ok  out  1  width_count == EXPECTED_WIDTH and no timeout.
- timeout  out  1  measurement aborted by TIMEOUT_CYCLES.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, meas_valid, delay_ok, width_ok and timeout are 0.
  - delay_count and width_count are 0.
  - pulse_in_q (registered pulse_in) is 0.
  - Reset overrides everything, including mid-measurement and mid-handshake. Any partial result is discarded.
- Edge detection: rise = pulse_in & ~pulse_in_q, where pulse_in_q is pulse_in delayed by one cycle.
- IDLE:
  - start == 1 moves to WAIT_RISE and clears the delay and width counters.
  - Result outputs hold their last values while in IDLE; they are meaningful only while meas_valid == 1.
- WAIT_RISE:
  - Each cycle without rise increments the delay counter.
  - On rise, the delay counter holds the delay and the state moves to MEAS_HIGH with the width counter set to 1. The rise cycle counts as the first high cycle.
  - Delay definition: if start is sampled in cycle S and rise occurs in cycle R, delay_count = R − S.
  - If pulse_in is already high when start is sampled, no rise exists; the block waits for the next rising edge.
  - If the delay counter reaches TIMEOUT_CYCLES, set timeout = 1 and go to REPORT. width_count is 0.
- MEAS_HIGH:
  - While pulse_in == 1, increment the width counter.
  - On the first low sample, go to REPORT. width_count = number of high cycles.
  - If the width counter reaches TIMEOUT_CYCLES, set timeout = 1 and go to REPORT.
- REPORT:
  - meas_valid = 1, asserted the cycle after the terminating event (first low sample or timeout).
  - delay_ok and width_ok are registered in the same cycle.
  - All result outputs are stable while meas_valid == 1 && meas_ready == 0.
  - On meas_valid && meas_ready, go to IDLE and deassert meas_valid next cycle.
  - meas_ready may be held high permanently; the result is then valid for exactly one cycle.
- start outside IDLE is ignored, including in the cycle of the handshake. It is not queued.
- Counters never wrap. TIMEOUT_CYCLES < 2^COUNT_W guarantees the timeout fires first.
- pulse_in activity while in REPORT or IDLE is ignored, apart from updating pulse_in_q.
- Minimum back-to-back spacing: a new start is accepted the cycle after the handshake.

Test Plan:
- Nominal: start high in cycle 10, pulse_in rises in cycle 15, high for 10 cycles, meas_ready = 1 → meas_valid one cycle after the first low sample; delay_count = 5, width_count = 10, delay_ok = 1, width_ok = 1, timeout = 0.
- Mismatch: delay 7, width 3 → delay_count = 7, width_count = 3, delay_ok = 0, width_ok = 0, timeout = 0.
- Backpressure: nominal pulse with meas_ready = 0 for 8 cycles after meas_valid → all outputs stable for 8 cycles; meas_valid drops the cycle after meas_ready = 1; busy = 0 afterwards.
- Timeout with TIMEOUT_CYCLES = 20 and no pulse after start → meas_valid with timeout = 1, delay_count = 20, width_count = 0, both ok flags 0. Also a stuck-high pulse → timeout = 1, width_count = 20.
- Pre-high and ignored start: pulse_in high when start is sampled, falls, then rises 4 cycles after start → delay_count = 4. A second start pulse during MEAS_HIGH has no effect on the results.
- Reset mid-MEAS_HIGH for 1 cycle → next cycle busy = 0, meas_valid = 0, counters 0; a following nominal start measures correctly (delay = 5, width = 10). Also drive pulse_generator directly: results must equal its start_delay_c and pulse_width_c.

Source files
------------

// File: rtl/pulse_measure.sv
// pulse_measure: measures start-to-rise delay and high width of pulse_in, checks them against expected values
module pulse_measure #(
   parameter int COUNT_W        = 16,
   parameter int EXPECTED_DELAY = 5,
   parameter int EXPECTED_WIDTH = 10,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               pulse_in,
   output logic               busy,
   output logic               meas_valid,
   input  logic               meas_ready,
   output logic [COUNT_W-1:0] delay_count,
   output logic [COUNT_W-1:0] width_count,
   output logic               delay_ok,
   output logic               width_ok,
   output logic               timeout
);
   typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, REPORT} state_t;
   localparam logic [COUNT_W-1:0] ONE   = COUNT_W'(1);
   localparam logic [COUNT_W-1:0] TO    = COUNT_W'(TIMEOUT_CYCLES);
   localparam logic [COUNT_W-1:0] TO_M1 = COUNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNT_W-1:0] EXP_D = COUNT_W'(EXPECTED_DELAY);
   localparam logic [COUNT_W-1:0] EXP_W = COUNT_W'(EXPECTED_WIDTH);
   state_t             state_q, state_d;
   logic [COUNT_W-1:0] delay_q, delay_d, width_q, width_d;
   logic               pulse_in_q, rise;
   logic               timeout_q, timeout_d, delay_ok_q, delay_ok_d, width_ok_q, width_ok_d;
   assign rise = pulse_in & ~pulse_in_q;
   always_comb begin
      state_d    = state_q;
      delay_d    = delay_q;
      width_d    = width_q;
      timeout_d  = timeout_q;
      delay_ok_d = delay_ok_q;
      width_ok_d = width_ok_q;
      case (state_q)
         IDLE: if (start) begin
            state_d    = WAIT_RISE;
            delay_d    = '0;
            width_d    = '0;
            timeout_d  = 1'b0;
            delay_ok_d = 1'b0;
            width_ok_d = 1'b0;
         end
         // The rise cycle itself is counted, so delay = rise cycle - start cycle.
         WAIT_RISE: begin
            delay_d = delay_q + ONE;
            if (rise) begin
               width_d   = ONE;
               timeout_d = (TO == ONE);
               state_d   = (TO == ONE) ? REPORT : MEAS_HIGH;
            end else if (delay_q >= TO_M1) begin
               timeout_d = 1'b1;
               state_d   = REPORT;
            end
         end
         MEAS_HIGH: if (!pulse_in) begin
            state_d = REPORT;
         end else begin
            width_d = width_q + ONE;
            if (width_q >= TO_M1) begin
               timeout_d = 1'b1;
               state_d   = REPORT;
            end
         end
         REPORT: if (meas_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_q != REPORT && state_d == REPORT) begin
         delay_ok_d = (delay_d == EXP_D) && !timeout_d;
         width_ok_d = (width_d == EXP_W) && !timeout_d;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         delay_q    <= '0;
         width_q    <= '0;
         timeout_q  <= 1'b0;
         delay_ok_q <= 1'b0;
         width_ok_q <= 1'b0;
         pulse_in_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         delay_q    <= delay_d;
         width_q    <= width_d;
         timeout_q  <= timeout_d;
         delay_ok_q <= delay_ok_d;
         width_ok_q <= width_ok_d;
         pulse_in_q <= pulse_in;
      end
   end
   assign busy        = (state_q != IDLE);
   assign meas_valid  = (state_q == REPORT);
   assign delay_count = delay_q;
   assign width_count = width_q;
   assign delay_ok    = delay_ok_q;
   assign width_ok    = width_ok_q;
   assign timeout     = timeout_q;
endmodule

// File: tb/tb_pulse_measure.sv
// tb_pulse_measure: scoreboard bench; directed pulses push expected results, a monitor checks each handshake
module tb_pulse_measure;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, pulse_in = 1'b0, meas_ready = 1'b1;
   logic        busy, meas_valid, delay_ok, width_ok, timeout;
   logic [15:0] delay_count, width_count;
   typedef struct packed {
      logic [15:0] d;
      logic [15:0] w;
      logic        dok;
      logic        wok;
      logic        to;
   } exp_t;
   exp_t        sb[$];
   exp_t        snap, cur, e;
   logic        have_snap = 1'b0;
   int          tests = 0, fails = 0;
   pulse_measure #(.COUNT_W(16), .EXPECTED_DELAY(5), .EXPECTED_WIDTH(10), .TIMEOUT_CYCLES(20)) dut (
      .clk(clk), .reset(reset), .start(start), .pulse_in(pulse_in), .busy(busy),
      .meas_valid(meas_valid), .meas_ready(meas_ready), .delay_count(delay_count),
      .width_count(width_count), .delay_ok(delay_ok), .width_ok(width_ok), .timeout(timeout)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", n, act, req);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input int d, input int w, input logic dok, input logic wok, input logic to);
      sb.push_back('{d: 16'(d), w: 16'(w), dok: dok, wok: wok, to: to});
   endtask
   // start sampled at edge E0; pulse_in high for edges E0+d .. E0+d+w-1
   task automatic run(input int d, input int w);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (d - 1) tick();
      pulse_in = 1'b1;
      repeat (w) tick();
      pulse_in = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((busy || meas_valid) && n < 300) begin
         tick();
         n++;
      end
      chk("idle_bound", 64'(busy | meas_valid), 0);
   endtask
   always @(negedge clk) begin
      if (reset) begin
         have_snap = 1'b0;
      end else if (meas_valid) begin
         cur = '{d: delay_count, w: width_count, dok: delay_ok, wok: width_ok, to: timeout};
         if (have_snap) chk("stable_under_backpressure", 64'(cur), 64'(snap));
         else begin
            snap      = cur;
            have_snap = 1'b1;
         end
         if (meas_ready) begin
            have_snap = 1'b0;
            if (sb.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               e = sb.pop_front();
               chk("delay_count", 64'(delay_count), 64'(e.d));
               chk("width_count", 64'(width_count), 64'(e.w));
               chk("delay_ok", 64'(delay_ok), 64'(e.dok));
               chk("width_ok", 64'(width_ok), 64'(e.wok));
               chk("timeout", 64'(timeout), 64'(e.to));
            end
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n;
      int dl[4] = '{1, 2, 12, 5};
      int wl[4] = '{1, 5, 3, 10};
      repeat (3) tick();
      chk("rst_busy", 64'(busy), 0);
      chk("rst_valid", 64'(meas_valid), 0);
      chk("rst_counts", 64'({delay_count, width_count}), 0);
      chk("rst_flags", 64'({delay_ok, width_ok, timeout}), 0);
      reset = 1'b0;
      repeat (5) tick();
      // nominal, including meas_valid latency after the first low sample
      push(5, 10, 1'b1, 1'b1, 1'b0);
      run(5, 10);
      chk("valid_not_early", 64'(meas_valid), 0);
      tick();
      chk("valid_after_low", 64'(meas_valid), 1);
      wait_idle();
      push(7, 3, 1'b0, 1'b0, 1'b0);
      run(7, 3);
      wait_idle();
      // backpressure; a start in the handshake cycle must be ignored
      meas_ready = 1'b0;
      push(5, 10, 1'b1, 1'b1, 1'b0);
      run(5, 10);
      n = 0;
      while (!meas_valid && n < 50) begin
         tick();
         n++;
      end
      chk("bp_valid_seen", 64'(meas_valid), 1);
      repeat (8) tick();
      meas_ready = 1'b1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      chk("bp_valid_drop", 64'(meas_valid), 0);
      chk("bp_busy_after", 64'(busy), 0);
      tick();
      push(20, 0, 1'b0, 1'b0, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle();
      push(3, 20, 1'b0, 1'b0, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      pulse_in = 1'b1;
      wait_idle();
      pulse_in = 1'b0;
      repeat (2) tick();
      // pulse already high at start, then a stray start during MEAS_HIGH
      pulse_in = 1'b1;
      repeat (2) tick();
      push(4, 10, 1'b0, 1'b1, 1'b0);
      start = 1'b1;
      tick();
      start    = 1'b0;
      pulse_in = 1'b0;
      repeat (3) tick();
      pulse_in = 1'b1;
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      pulse_in = 1'b0;
      wait_idle();
      // reset in the middle of MEAS_HIGH discards the partial result
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      pulse_in = 1'b1;
      repeat (4) tick();
      reset    = 1'b1;
      pulse_in = 1'b0;
      tick();
      reset = 1'b0;
      chk("midrst_busy", 64'(busy), 0);
      chk("midrst_valid", 64'(meas_valid), 0);
      chk("midrst_counts", 64'({delay_count, width_count}), 0);
      push(5, 10, 1'b1, 1'b1, 1'b0);
      run(5, 10);
      wait_idle();
      // generator-style (start_delay, pulse_width) pairs
      for (int i = 0; i < 4; i++) begin
         push(dl[i], wl[i], dl[i] == 5, wl[i] == 10, 1'b0);
         run(dl[i], wl[i]);
         wait_idle();
         tick();
      end
      repeat (3) tick();
      chk("scoreboard_empty", 64'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
